coproc_sram_arb: RTL
====================

# coproc_sram_arb

Parametrised on-chip RAM for the coprocessor soft-CPU subsystem with two Avalon-MM slave ports, s1 and s2, arbitrated onto one single-port memory array.
- s1 serves the Nios II data master; s2 serves the coprocessor DMA/streaming engine.
- Adds waitrequest, pipelined reads with readdatavalid, and round-robin fairness.
- Adds a selectable output register and out-of-range address protection.
- Depth, width and initial contents are set by parameters, so one block covers firmware RAM and scratch buffers.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 12, word-address width of each port.
- DEPTH, 2560, number of implemented words; must be ≤ 2^ADDR_W.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- INIT_FILE, "", memory initialisation file; empty means contents are undefined at power-up.
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- clken  in  1  global clock enable; low freezes the block.
- reset_req  in  1  high blocks new grants and freezes the pipeline.
- sN_address  in  ADDR_W  word address (N = 1, 2).
- sN_byteenable  in  DATA_W/8  byte lane write enables.
- sN_chipselect  in  1  port select.
- sN_read  in  1  read request.
- sN_write  in  1  write request.
- sN_writedata  in  DATA_W  write data.
- sN_readdata  out  DATA_W  read data; meaningful only while sN_readdatavalid is high.
- sN_waitrequest  out  1  request not accepted this cycle.
- sN_readdatavalid  out  1  one-cycle pulse per accepted read.

## Operation
- Request: reqN = sN_chipselect & (sN_read | sN_write).
- If sN_write and sN_read are both high, the access is a write: no readdatavalid is produced.
- Enable: en = clken & ~reset_req.
- Arbitration with en high:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not granted last is granted.
  - The last-grant pointer updates only on a grant.
  - After reset the pointer equals s2, so s1 wins the first tie.
- Waitrequest: sN_waitrequest = reqN & ~(grantN & en). It is combinational, and the master holds its request until waitrequest is low.
- Writes: on a granted write, each byte lane with its byteenable bit set is written at the clock edge. Lanes with the bit clear are unchanged.
- Reads: a granted read enters a pipeline tagged with the port number.
  - Data and valid leave after 1 + OUT_REG cycles, on the tagged port only.
  - The readdata of the other port holds its previous value.
- Out of range (address ≥ DEPTH): writes are dropped. Reads complete normally with readdata = 0.
- Freeze (en low): no grants. All pipeline registers, valids and the pointer hold. readdatavalid does not pulse while frozen. A valid that is pending re-emerges after en returns high.
- Reset (reset_n low, any time):
  - Pipeline valids clear, so outstanding reads are discarded and never pulse later.
  - sN_readdata = 0 and sN_readdatavalid = 0.
  - sN_waitrequest follows reqN (no grants during reset).
  - The pointer is set to s2.
  - Memory contents are retained.
- Total throughput is one access per cycle, shared by both ports.

## Timing
- A request granted in cycle T (waitrequest low at edge T):
  - A write is visible to any read granted in T+1 or later.
  - A read asserts readdatavalid in T+1 (OUT_REG=0) or T+2 (OUT_REG=1).
- Back-to-back granted reads give back-to-back valid pulses, in order of grant.
- A write and a read to the same address are never granted in the same cycle, so there is no read-during-write hazard.
- The reset deassertion edge is synchronised internally to clk (two flops) before the first grant. The earliest grant is the third rising edge after reset_n rises.
- Reset values:
  - All readdata and readdatavalid outputs are 0.
  - waitrequest equals reqN.

## Test plan
- s1 writes 0xDEADBEEF to address 5 with byteenable 0xF, then reads address 5 -> readdatavalid pulses 1 cycle after the read grant with 0xDEADBEEF. s2 readdatavalid stays 0.
- s2 writes 0x12345678 to address 5 with byteenable 0x3, then s1 reads address 5 -> 0xDEAD5678.
- Both ports issue reads of addresses 0..3 continuously -> grants alternate s1, s2, s1, s2. Each port sees waitrequest high on alternate cycles. No read is lost or duplicated.
- OUT_REG=1: four back-to-back s1 reads of addresses 8..11 preloaded with 0xA0..0xA3 -> valid pulses on 4 consecutive cycles starting 2 cycles after the first grant, data in order.
- clken low for 3 cycles with one read outstanding -> no valid pulse during freeze. The valid appears on the correct cycle after clken returns high. Repeating the test with reset_n pulsed instead -> no valid pulse at all, and address 5 still reads 0xDEAD5678 afterwards.
- s1 writes 0xFFFFFFFF to address 2560, then reads address 2560 -> data 0. Address 0 is unchanged.

Source files
------------

// File: rtl/coproc_sram_arb.sv
// Two-port Avalon-MM RAM: s1 and s2 share one single-port array under round-robin
// arbitration, with pipelined reads, an optional output register and out-of-range protection.
module coproc_sram_arb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 2560,
    parameter int OUT_REG   = 0,
    parameter     INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic                reset_req,

    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_waitrequest,
    output logic                s1_readdatavalid,

    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_waitrequest,
    output logic                s2_readdatavalid
);

    localparam int              BE_W    = DATA_W / 8;
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic            PTR_S1  = 1'b0;
    localparam logic            PTR_S2  = 1'b1;

    // Contents are preloaded by the FPGA memory-init flow when INIT_FILE is set.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        r_rst_sync;
    logic              r_last;
    logic              r_a_v;
    logic              r_a_tag;
    logic [DATA_W-1:0] r_a_data;
    logic              r_rv1;
    logic              r_rv2;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;

    logic              w_en;
    logic              w_req1;
    logic              w_req2;
    logic              w_gnt1;
    logic              w_gnt2;
    logic              w_acc;
    logic [ADDR_W-1:0] w_addr;
    logic [IDX_W-1:0]  w_idx;
    logic              w_wr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range;
    logic              w_wr_go;
    logic              w_rd_go;
    logic [DATA_W-1:0] w_mem_q;
    logic              w_p_v;
    logic              w_p_tag;
    logic [DATA_W-1:0] w_p_data;

    // Release of reset is re-timed so the first grant lands on the third edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_en   = clken & ~reset_req & r_rst_sync[1];
    assign w_req1 = s1_chipselect & (s1_read | s1_write);
    assign w_req2 = s2_chipselect & (s2_read | s2_write);
    assign w_gnt1 = w_req1 & (~w_req2 | (r_last == PTR_S2));
    assign w_gnt2 = w_req2 & ~w_gnt1;
    assign w_acc  = w_en & (w_gnt1 | w_gnt2);

    assign s1_waitrequest = w_req1 & ~(w_gnt1 & w_en);
    assign s2_waitrequest = w_req2 & ~(w_gnt2 & w_en);

    assign w_addr     = w_gnt2 ? s2_address    : s1_address;
    assign w_wr       = w_gnt2 ? s2_write      : s1_write;
    assign w_be       = w_gnt2 ? s2_byteenable : s1_byteenable;
    assign w_wdata    = w_gnt2 ? s2_writedata  : s1_writedata;
    assign w_idx      = w_addr[IDX_W-1:0];
    assign w_in_range = ({1'b0, w_addr} < DEPTH_C);
    assign w_wr_go    = w_acc & w_wr & w_in_range;
    assign w_rd_go    = w_acc & ~w_wr;
    assign w_mem_q    = w_in_range ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= PTR_S2;
        end else if (w_acc) begin
            r_last <= w_gnt2 ? PTR_S2 : PTR_S1;
        end
    end

    // Optional extra stage; bypassed entirely when OUT_REG is 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_v    <= 1'b0;
            r_a_tag  <= 1'b0;
            r_a_data <= '0;
        end else if (w_en) begin
            r_a_v <= w_rd_go;
            if (w_rd_go) begin
                r_a_tag  <= w_gnt2;
                r_a_data <= w_mem_q;
            end
        end
    end

    assign w_p_v    = (OUT_REG != 0) ? r_a_v    : w_rd_go;
    assign w_p_tag  = (OUT_REG != 0) ? r_a_tag  : w_gnt2;
    assign w_p_data = (OUT_REG != 0) ? r_a_data : w_mem_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rv1 <= 1'b0;
            r_rv2 <= 1'b0;
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (w_en) begin
            r_rv1 <= w_p_v & ~w_p_tag;
            r_rv2 <= w_p_v & w_p_tag;
            if (w_p_v & ~w_p_tag) r_rd1 <= w_p_data;
            if (w_p_v & w_p_tag)  r_rd2 <= w_p_data;
        end
    end

    // A valid held across a freeze stays hidden until the block is enabled again.
    assign s1_readdatavalid = r_rv1 & w_en;
    assign s2_readdatavalid = r_rv2 & w_en;
    assign s1_readdata      = r_rd1;
    assign s2_readdata      = r_rd2;

endmodule
